// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: drives the model reset, paces move strobes by level,
// and runs the start / countdown / play / pause / game-over flow with a session high score.
module snake_game_ctrl #(
   parameter int unsigned TICK_BASE    = 10000000,
   parameter int unsigned TICK_DEC     = 1000000,
   parameter int unsigned TICK_MIN     = 2000000,
   parameter int unsigned LEVEL_STEP   = 5,
   parameter int unsigned MAX_LEVEL    = 7,
   parameter int unsigned COUNTDOWN    = 3,
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        pause_i,
   input  logic        game_over_i,
   input  logic [15:0] score_i,
   output logic        model_rst_n_o,
   output logic        step_o,
   output logic [2:0]  state_o,
   output logic [2:0]  level_o,
   output logic [1:0]  countdown_o,
   output logic [15:0] high_score_o
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StClear = 3'd1,
      StCount = 3'd2,
      StPlay  = 3'd3,
      StPause = 3'd4,
      StOver  = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic        start_q, pause_q;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  level_q, level_d;
   logic [1:0]  countdown_q, countdown_d;
   logic [15:0] high_score_q, high_score_d;
   logic        model_rst_n_q, model_rst_n_d;

   logic        start_rise, pause_rise, boundary;
   logic [31:0] lvl_dec, lvl_raw, period;

   assign start_rise = start_i & ~start_q;
   assign pause_rise = pause_i & ~pause_q;

   always_comb begin
      lvl_dec = 32'(level_q) * TICK_DEC;
      lvl_raw = 32'(score_i) / LEVEL_STEP;
      if (state_q == StCount) begin
         period = TICK_BASE;
      end else if (lvl_dec >= TICK_BASE - TICK_MIN) begin
         period = TICK_MIN;
      end else begin
         period = TICK_BASE - lvl_dec;
      end
   end

   // >= rather than == so a period that shrinks below cnt still wraps promptly
   assign boundary = (cnt_q >= period - 32'd1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_rise) state_d = StClear;
         StClear: if (cnt_q == RESET_CYCLES - 1) state_d = StCount;
         StCount: if (boundary && countdown_q == 2'd1) state_d = StPlay;
         StPlay: begin
            if (game_over_i)     state_d = StOver;
            else if (pause_rise) state_d = StPause;
         end
         StPause: begin
            if (start_rise)      state_d = StClear;
            else if (pause_rise) state_d = StPlay;
         end
         StOver:  if (start_rise) state_d = StClear;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         // Pause freezes the period counter in both directions
         if ((state_q == StPlay && state_d == StPause) ||
             (state_q == StPause && state_d == StPlay)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = '0;
         end
      end else if (state_q == StClear) begin
         cnt_d = cnt_q + 32'd1;
      end else if (state_q == StCount || state_q == StPlay) begin
         cnt_d = boundary ? '0 : cnt_q + 32'd1;
      end

      level_d = level_q;
      if (state_d == StClear) begin
         level_d = '0;
      end else if (state_q == StPlay) begin
         level_d = (lvl_raw > MAX_LEVEL) ? 3'(MAX_LEVEL) : 3'(lvl_raw);
      end

      countdown_d = '0;
      if (state_d == StCount) begin
         if (state_q != StCount) countdown_d = 2'(COUNTDOWN);
         else if (boundary)      countdown_d = countdown_q - 2'd1;
         else                    countdown_d = countdown_q;
      end

      high_score_d = high_score_q;
      if (state_q == StPlay && state_d == StOver && score_i > high_score_q) begin
         high_score_d = score_i;
      end

      model_rst_n_d = (state_d == StCount) || (state_d == StPlay) ||
                      (state_d == StPause) || (state_d == StOver);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         start_q       <= 1'b0;
         pause_q       <= 1'b0;
         cnt_q         <= '0;
         level_q       <= '0;
         countdown_q   <= '0;
         high_score_q  <= '0;
         model_rst_n_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_i;
         pause_q       <= pause_i;
         cnt_q         <= cnt_d;
         level_q       <= level_d;
         countdown_q   <= countdown_d;
         high_score_q  <= high_score_d;
         model_rst_n_q <= model_rst_n_d;
      end
   end

   // Strobe is dropped in the cycle PLAY exits so no move lands on a dead game
   assign step_o        = (state_q == StPlay) && boundary && !game_over_i && !pause_rise;
   assign state_o       = state_q;
   assign level_o       = level_q;
   assign countdown_o   = countdown_q;
   assign high_score_o  = high_score_q;
   assign model_rst_n_o = model_rst_n_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with small tick parameters and hand-computed timings.
module tb_snake_game_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, pause, game_over;
   logic [15:0] score;
   logic        model_rst_n, step;
   logic [2:0]  state, level;
   logic [1:0]  countdown;
   logic [15:0] high_score;

   int n_cmp = 0;
   int n_err = 0;

   snake_game_ctrl #(
      .TICK_BASE    (20),
      .TICK_DEC     (4),
      .TICK_MIN     (8),
      .LEVEL_STEP   (2),
      .MAX_LEVEL    (3),
      .COUNTDOWN    (3),
      .RESET_CYCLES (4)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .pause_i       (pause),
      .game_over_i   (game_over),
      .score_i       (score),
      .model_rst_n_o (model_rst_n),
      .step_o        (step),
      .state_o       (state),
      .level_o       (level),
      .countdown_o   (countdown),
      .high_score_o  (high_score)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic count_while(input logic [2:0] st, input logic [1:0] cd, output int n);
      n = 0;
      while (state == st && countdown == cd && n < 500) begin
         n++;
         nxt();
      end
   endtask

   // Cycles from the current one up to and including the next step; -1 on timeout
   task automatic wait_step(output int n);
      n = 1;
      while (!step && n < 200) begin
         nxt();
         n++;
      end
      if (!step) n = -1;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st);
      int k = 0;
      while (state != st && k < 500) begin
         nxt();
         k++;
      end
      check_eq(tag, state, st);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      nxt();
      start = 1'b0;
   endtask

   initial begin
      int n, steps, bad_state;
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; game_over = 1'b0; score = 16'd0;
      repeat (2) nxt();
      check_eq("rst_state", state, 0);
      check_eq("rst_mrst", model_rst_n, 0);
      check_eq("rst_step", step, 0);
      check_eq("rst_level", level, 0);
      check_eq("rst_cd", countdown, 0);
      check_eq("rst_high", high_score, 0);
      rst_n = 1'b1;
      nxt();

      // 1. start, clear, countdown, first steps
      pulse_start();
      check_eq("clear_state", state, 1);
      check_eq("clear_mrst", model_rst_n, 0);
      count_while(3'd1, 2'd0, n);
      check_eq("clear_len", n, 4);
      check_eq("count_state", state, 2);
      check_eq("count_mrst", model_rst_n, 1);
      count_while(3'd2, 2'd3, n);
      check_eq("cd3_len", n, 20);
      count_while(3'd2, 2'd2, n);
      check_eq("cd2_len", n, 20);
      count_while(3'd2, 2'd1, n);
      check_eq("cd1_len", n, 20);
      check_eq("play_state", state, 3);
      check_eq("play_cd", countdown, 0);
      wait_step(n);
      check_eq("first_step", n, 20);
      nxt();
      wait_step(n);
      check_eq("step_gap20", n, 20);

      // 3. pause after five counted cycles, resume with fifteen left
      repeat (6) nxt();
      pause = 1'b1;
      #1;
      check_eq("pause_nostep", step, 0);
      nxt();
      pause = 1'b0;
      check_eq("pause_state", state, 4);
      steps = 0; bad_state = 0;
      repeat (100) begin
         nxt();
         if (step) steps++;
         if (state != 3'd4) bad_state++;
      end
      check_eq("pause_steps", steps, 0);
      check_eq("pause_hold", bad_state, 0);
      pause = 1'b1;
      nxt();
      pause = 1'b0;
      check_eq("resume_state", state, 3);
      wait_step(n);
      check_eq("resume_gap", n, 15);

      // 2. level speed-up and clamp
      score = 16'd4;
      nxt();
      check_eq("level2", level, 2);
      wait_step(n);
      check_eq("gap_lvl2_a", n, 12);
      nxt();
      wait_step(n);
      check_eq("gap_lvl2_b", n, 12);
      score = 16'd20;
      nxt();
      check_eq("level3", level, 3);
      wait_step(n);
      check_eq("gap_lvl3", n, 8);

      // 4. game over on a boundary cycle, high score
      repeat (8) nxt();
      check_eq("pre_exit_step", step, 1);
      game_over = 1'b1;
      score = 16'd5;
      #1;
      check_eq("exit_nostep", step, 0);
      nxt();
      game_over = 1'b0;
      check_eq("over_state", state, 5);
      check_eq("over_high", high_score, 5);
      check_eq("over_mrst", model_rst_n, 1);
      score = 16'd0;
      pulse_start();
      check_eq("restart_state", state, 1);
      check_eq("restart_level", level, 0);
      check_eq("restart_high", high_score, 5);
      wait_state("to_play2", 3'd3);
      game_over = 1'b1;
      score = 16'd3;
      nxt();
      game_over = 1'b0;
      check_eq("over2_state", state, 5);
      check_eq("over2_high", high_score, 5);

      // 5. priority cases
      score = 16'd0;
      pulse_start();
      wait_state("to_play3", 3'd3);
      repeat (3) nxt();
      game_over = 1'b1;
      pause = 1'b1;
      nxt();
      game_over = 1'b0;
      pause = 1'b0;
      check_eq("go_over_pause", state, 5);
      pulse_start();
      wait_state("to_play4", 3'd3);
      pause = 1'b1;
      nxt();
      pause = 1'b0;
      check_eq("pause2_state", state, 4);
      nxt();
      start = 1'b1;
      pause = 1'b1;
      nxt();
      start = 1'b0;
      pause = 1'b0;
      check_eq("start_over_pause", state, 1);

      // 6. asynchronous reset mid-play
      score = 16'd6;
      wait_state("to_play5", 3'd3);
      repeat (3) nxt();
      check_eq("pre_rst_level", level, 3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_state", state, 0);
      check_eq("arst_step", step, 0);
      check_eq("arst_mrst", model_rst_n, 0);
      check_eq("arst_high", high_score, 0);
      check_eq("arst_level", level, 0);
      nxt();
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
